// File: rtl/cacheline_arbiter_pkg.sv
// Shared line geometry and state/source encodings for the cacheline arbiter.
// Both caches reuse LINE_WIDTH/LINE_OFFSET from here.
package mem_types;

    localparam int LINE_WIDTH  = 256;
    localparam int LINE_OFFSET = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_I    = 2'd1,
        SRC_D    = 2'd2
    } arb_src_t;

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Bundle of icache, dcache and memory-side signals around the cacheline arbiter.
// slave is the arbiter's view; master is the environment's view.
interface cacheline_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_read;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic                  d_read;
    logic                  d_write;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic                  m_read;
    logic                  m_write;
    logic [LINE_WIDTH-1:0] m_wdata;
    logic [LINE_WIDTH-1:0] m_rdata;
    logic                  m_resp;

    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, m_rdata, m_resp,
        output i_rdata, i_resp, d_rdata, d_resp, m_addr, m_read, m_write, m_wdata
    );

    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata, m_rdata, m_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, m_addr, m_read, m_write, m_wdata
    );
endinterface

// File: rtl/cacheline_arb_pick.sv
// Combinational winner select between icache and dcache requests.
// CACHELINE_ARB_RR_EN switches from fixed dcache priority to round-robin.
module cacheline_arb_pick
    import mem_types::*;
(
    input  logic     i_i_req,
    input  logic     i_d_req,
`ifdef CACHELINE_ARB_RR_EN
    input  logic     i_last_d,
`endif
    output arb_src_t o_winner
);

    // Winner select; on a tie the round-robin build favours whoever did not win last.
    always_comb begin
        o_winner = SRC_NONE;
`ifdef CACHELINE_ARB_RR_EN
        if (i_i_req && i_d_req) begin
            o_winner = i_last_d ? SRC_I : SRC_D;
        end else if (i_d_req) begin
            o_winner = SRC_D;
        end else if (i_i_req) begin
            o_winner = SRC_I;
        end else begin
            o_winner = SRC_NONE;
        end
`else
        if (i_d_req) begin
            o_winner = SRC_D;
        end else if (i_i_req) begin
            o_winner = SRC_I;
        end else begin
            o_winner = SRC_NONE;
        end
`endif
    end

endmodule

// File: rtl/cacheline_arbiter_chk.sv
// Protocol checks on the arbiter's requester and memory sides.
module cacheline_arbiter_chk #(
    parameter int ADDR_WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  i_read,
    input logic                  i_resp,
    input logic [ADDR_WIDTH-1:0] i_addr,
    input logic                  d_read,
    input logic                  d_write,
    input logic                  d_resp,
    input logic [ADDR_WIDTH-1:0] d_addr,
    input logic                  m_resp,
    input logic                  busy
);

    a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst)
        !(d_read && d_write));

    a_i_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        (i_read && !i_resp) |=> (!i_read || $stable(i_addr)));

    a_d_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        ((d_read || d_write) && !d_resp) |=> (!(d_read || d_write) || $stable(d_addr)));

    a_m_resp_busy: assert property (@(posedge clk) disable iff (!rst)
        m_resp |-> busy);

endmodule

// File: rtl/cacheline_arbiter.sv
// Non-pipelined icache/dcache to memory cacheline arbiter (IDLE/BUSY/RESP).
// Optional round-robin arbitration under CACHELINE_ARB_RR_EN.
module cacheline_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input logic                clk,
    input logic                rst,
    cacheline_arbiter_if.slave bus
);
    import mem_types::*;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        {{(ADDR_WIDTH - mem_types::LINE_OFFSET){1'b1}}, {mem_types::LINE_OFFSET{1'b0}}};

    arb_state_t            r_state, w_state_nxt;
    arb_src_t              r_owner, w_owner_nxt, w_winner;
    logic [ADDR_WIDTH-1:0] r_m_addr, w_m_addr_nxt;
    logic                  r_m_read, w_m_read_nxt;
    logic                  r_m_write, w_m_write_nxt;
    logic [LINE_WIDTH-1:0] r_m_wdata, w_m_wdata_nxt;
    logic [LINE_WIDTH-1:0] r_i_rdata, w_i_rdata_nxt;
    logic [LINE_WIDTH-1:0] r_d_rdata, w_d_rdata_nxt;
    logic                  r_i_resp, w_i_resp_nxt;
    logic                  r_d_resp, w_d_resp_nxt;
    logic                  w_d_req;

    assign w_d_req = bus.d_read | bus.d_write;

`ifdef CACHELINE_ARB_RR_EN
    logic r_last_d;

    // Last-owner record for round-robin, updated on every grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d <= 1'b0;
        end else if ((r_state == IDLE) && (w_winner != SRC_NONE)) begin
            r_last_d <= (w_winner == SRC_D);
        end else begin
            r_last_d <= r_last_d;
        end
    end

    cacheline_arb_pick u_pick (
        .i_i_req  (bus.i_read),
        .i_d_req  (w_d_req),
        .i_last_d (r_last_d),
        .o_winner (w_winner)
    );
`else
    cacheline_arb_pick u_pick (
        .i_i_req  (bus.i_read),
        .i_d_req  (w_d_req),
        .o_winner (w_winner)
    );
`endif

    // Next-state and next-output logic; a write wins if dcache raises both read and write.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_m_addr_nxt  = r_m_addr;
        w_m_read_nxt  = r_m_read;
        w_m_write_nxt = r_m_write;
        w_m_wdata_nxt = r_m_wdata;
        w_i_rdata_nxt = r_i_rdata;
        w_d_rdata_nxt = r_d_rdata;
        w_i_resp_nxt  = 1'b0;
        w_d_resp_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_winner == SRC_D) begin
                    w_owner_nxt   = SRC_D;
                    w_state_nxt   = BUSY;
                    w_m_addr_nxt  = bus.d_addr & ADDR_MASK;
                    w_m_wdata_nxt = bus.d_wdata;
                    w_m_write_nxt = bus.d_write;
                    w_m_read_nxt  = ~bus.d_write;
                end else if (w_winner == SRC_I) begin
                    w_owner_nxt   = SRC_I;
                    w_state_nxt   = BUSY;
                    w_m_addr_nxt  = bus.i_addr & ADDR_MASK;
                    w_m_wdata_nxt = {LINE_WIDTH{1'b0}};
                    w_m_write_nxt = 1'b0;
                    w_m_read_nxt  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (bus.m_resp) begin
                    w_state_nxt   = RESP;
                    w_m_read_nxt  = 1'b0;
                    w_m_write_nxt = 1'b0;
                    if (r_owner == SRC_I) begin
                        w_i_rdata_nxt = bus.m_rdata;
                        w_i_resp_nxt  = 1'b1;
                    end else if (r_owner == SRC_D) begin
                        w_d_rdata_nxt = r_m_write ? r_d_rdata : bus.m_rdata;
                        w_d_resp_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = RESP;
                    end
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                w_owner_nxt = SRC_NONE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_owner_nxt = SRC_NONE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_owner   <= SRC_NONE;
            r_m_addr  <= {ADDR_WIDTH{1'b0}};
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
            r_m_wdata <= {LINE_WIDTH{1'b0}};
            r_i_rdata <= {LINE_WIDTH{1'b0}};
            r_d_rdata <= {LINE_WIDTH{1'b0}};
            r_i_resp  <= 1'b0;
            r_d_resp  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_m_addr  <= w_m_addr_nxt;
            r_m_read  <= w_m_read_nxt;
            r_m_write <= w_m_write_nxt;
            r_m_wdata <= w_m_wdata_nxt;
            r_i_rdata <= w_i_rdata_nxt;
            r_d_rdata <= w_d_rdata_nxt;
            r_i_resp  <= w_i_resp_nxt;
            r_d_resp  <= w_d_resp_nxt;
        end
    end

    assign bus.m_addr  = r_m_addr;
    assign bus.m_read  = r_m_read;
    assign bus.m_write = r_m_write;
    assign bus.m_wdata = r_m_wdata;
    assign bus.i_rdata = r_i_rdata;
    assign bus.i_resp  = r_i_resp;
    assign bus.d_rdata = r_d_rdata;
    assign bus.d_resp  = r_d_resp;

    cacheline_arbiter_chk #(.ADDR_WIDTH(ADDR_WIDTH)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .i_read  (bus.i_read),
        .i_resp  (r_i_resp),
        .i_addr  (bus.i_addr),
        .d_read  (bus.d_read),
        .d_write (bus.d_write),
        .d_resp  (r_d_resp),
        .d_addr  (bus.d_addr),
        .m_resp  (bus.m_resp),
        .busy    (r_state == BUSY)
    );

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter: vector table of single transactions
// plus hand sequences for simultaneous requests, long memory latency and reset abort.
module tb_cacheline_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    cacheline_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) bus ();

    cacheline_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_d;
        logic         is_wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] mrdata;
        int           delay;
        logic [31:0]  exp_maddr;
        logic [255:0] exp_mwdata;
        logic [255:0] exp_i;
        logic [255:0] exp_d;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One memory transaction; the request must already be driven before the grant edge.
    task automatic mem_txn(input string tag, input logic [31:0] exp_addr, input logic exp_wr,
                           input logic [255:0] exp_wdata, input int delay,
                           input logic [255:0] mrdata, input logic own_d,
                           input logic [255:0] exp_i, input logic [255:0] exp_d);
        @(posedge clk);
        @(negedge clk);
        check({tag, " m_addr"}, bus.m_addr, exp_addr);
        check({tag, " m_read"}, bus.m_read, !exp_wr);
        check({tag, " m_write"}, bus.m_write, exp_wr);
        check({tag, " m_wdata"}, bus.m_wdata, exp_wdata);
        check({tag, " early resp"}, {bus.i_resp, bus.d_resp}, 2'b00);
        for (int k = 0; k < delay; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, " hold m_addr"}, bus.m_addr, exp_addr);
            check({tag, " hold m_rw"}, {bus.m_read, bus.m_write}, {!exp_wr, exp_wr});
            check({tag, " hold m_wdata"}, bus.m_wdata, exp_wdata);
            check({tag, " hold no resp"}, {bus.i_resp, bus.d_resp}, 2'b00);
        end
        @(posedge clk);
        #1;
        bus.m_resp  = 1'b1;
        bus.m_rdata = mrdata;
        @(posedge clk);
        #1;
        bus.m_resp  = 1'b0;
        bus.m_rdata = {256{1'b1}};
        @(negedge clk);
        check({tag, " i_resp"}, bus.i_resp, !own_d);
        check({tag, " d_resp"}, bus.d_resp, own_d);
        check({tag, " i_rdata"}, bus.i_rdata, exp_i);
        check({tag, " d_rdata"}, bus.d_rdata, exp_d);
        check({tag, " m_rw dropped"}, {bus.m_read, bus.m_write}, 2'b00);
        @(posedge clk);
        #1;
        if (own_d) begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
        end else begin
            bus.i_read = 1'b0;
        end
        @(negedge clk);
        check({tag, " resp one cycle"}, {bus.i_resp, bus.d_resp}, 2'b00);
        check({tag, " idle m_rw"}, {bus.m_read, bus.m_write}, 2'b00);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_1234, 256'h0, {8{32'hA5A5_A5A5}}, 2,
                    32'h0000_1220, 256'h0, {8{32'hA5A5_A5A5}}, {8{32'h4444_4444}}};
        vecs[1] = '{1'b1, 1'b1, 32'h8000_0040, {8{32'h1111_1111}}, {8{32'hDEAD_BEEF}}, 1,
                    32'h8000_0040, {8{32'h1111_1111}}, {8{32'hA5A5_A5A5}}, {8{32'h4444_4444}}};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_021F, {8{32'h7777_7777}}, {8{32'h5A5A_0F0F}}, 0,
                    32'h0000_0200, {8{32'h7777_7777}}, {8{32'hA5A5_A5A5}}, {8{32'h5A5A_0F0F}}};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 256'h0, {8{32'h0123_4567}}, 3,
                    32'hFFFF_FFE0, 256'h0, {8{32'h0123_4567}}, {8{32'h5A5A_0F0F}}};
        vecs[4] = '{1'b1, 1'b0, 32'h1000_0005, {8{32'h9999_9999}}, {8{32'hCAFE_F00D}}, 49,
                    32'h1000_0000, {8{32'h9999_9999}}, {8{32'h0123_4567}}, {8{32'hCAFE_F00D}}};

        rst         = 1'b0;
        bus.i_addr  = 32'h0;
        bus.i_read  = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_wdata = 256'h0;
        bus.m_rdata = 256'h0;
        bus.m_resp  = 1'b0;
        #1;
        check("reset m_rw", {bus.m_read, bus.m_write}, 2'b00);
        check("reset m_addr", bus.m_addr, 32'h0);
        check("reset resp", {bus.i_resp, bus.d_resp}, 2'b00);
        check("reset i_rdata", bus.i_rdata, 256'h0);
        check("reset d_rdata", bus.d_rdata, 256'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Simultaneous icache/dcache reads twice: dcache first each time in both builds.
        for (int r = 0; r < 2; r++) begin
            logic [31:0]  ia, da;
            logic [255:0] dd, id, prev_i;
            ia     = (r == 0) ? 32'h0000_0100 : 32'h0000_0140;
            da     = (r == 0) ? 32'h0000_0200 : 32'h0000_0260;
            dd     = (r == 0) ? {8{32'h2222_2222}} : {8{32'h4444_4444}};
            id     = (r == 0) ? {8{32'h3333_3333}} : {8{32'h5555_5555}};
            prev_i = (r == 0) ? 256'h0 : {8{32'h3333_3333}};
            @(posedge clk);
            #1;
            bus.i_addr = ia;
            bus.i_read = 1'b1;
            bus.d_addr = da;
            bus.d_read = 1'b1;
            mem_txn($sformatf("sim%0d_d", r), da, 1'b0, 256'h0, 0, dd, 1'b1, prev_i, dd);
            mem_txn($sformatf("sim%0d_i", r), ia, 1'b0, 256'h0, 1, id, 1'b0, id, dd);
        end

        for (int v = 0; v < 5; v++) begin
            @(posedge clk);
            #1;
            if (vecs[v].is_d) begin
                bus.d_addr  = vecs[v].addr;
                bus.d_wdata = vecs[v].wdata;
                bus.d_write = vecs[v].is_wr;
                bus.d_read  = !vecs[v].is_wr;
            end else begin
                bus.i_addr = vecs[v].addr;
                bus.i_read = 1'b1;
            end
            mem_txn($sformatf("vec%0d", v), vecs[v].exp_maddr, vecs[v].is_wr, vecs[v].exp_mwdata,
                    vecs[v].delay, vecs[v].mrdata, vecs[v].is_d, vecs[v].exp_i, vecs[v].exp_d);
        end

        // Tie after a dcache grant: fixed priority picks dcache, round-robin picks icache.
        @(posedge clk);
        #1;
        bus.d_wdata = 256'h0;
        bus.i_addr  = 32'h0000_0500;
        bus.i_read  = 1'b1;
        bus.d_addr  = 32'h0000_0600;
        bus.d_read  = 1'b1;
`ifdef CACHELINE_ARB_RR_EN
        mem_txn("tie_i", 32'h0000_0500, 1'b0, 256'h0, 0, {8{32'h8888_8888}}, 1'b0,
                {8{32'h8888_8888}}, {8{32'hCAFE_F00D}});
        mem_txn("tie_d", 32'h0000_0600, 1'b0, 256'h0, 0, {8{32'h6666_6666}}, 1'b1,
                {8{32'h8888_8888}}, {8{32'h6666_6666}});
`else
        mem_txn("tie_d", 32'h0000_0600, 1'b0, 256'h0, 0, {8{32'h6666_6666}}, 1'b1,
                {8{32'h0123_4567}}, {8{32'h6666_6666}});
        mem_txn("tie_i", 32'h0000_0500, 1'b0, 256'h0, 0, {8{32'h8888_8888}}, 1'b0,
                {8{32'h8888_8888}}, {8{32'h6666_6666}});
`endif

        // Reset while BUSY: outputs clear at once and the aborted read never responds.
        @(posedge clk);
        #1;
        bus.i_addr = 32'h0000_3000;
        bus.i_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort m_read before", bus.m_read, 1'b1);
        #2;
        rst        = 1'b0;
        bus.i_read = 1'b0;
        #1;
        check("abort m_rw", {bus.m_read, bus.m_write}, 2'b00);
        check("abort m_addr", bus.m_addr, 32'h0);
        check("abort i_rdata", bus.i_rdata, 256'h0);
        check("abort d_rdata", bus.d_rdata, 256'h0);
        check("abort resp", {bus.i_resp, bus.d_resp}, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("post abort quiet", {bus.m_read, bus.m_write, bus.i_resp, bus.d_resp}, 4'b0000);
        end

        @(posedge clk);
        #1;
        bus.i_addr = 32'h0000_0040;
        bus.i_read = 1'b1;
        mem_txn("recover", 32'h0000_0040, 1'b0, 256'h0, 1, {8{32'h7777_7777}}, 1'b0,
                {8{32'h7777_7777}}, 256'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Sits directly downstream of the LSU's data cache and the instruction cache, and feeds the single memory-side cacheline adapter.
- Accepts full-line read requests from icache and read/write requests from dcache, grants one at a time, and forwards it to memory.
- Registers memory read data back to the granted requester.
- Non-pipelined: one outstanding memory transaction at a time.

Parameters:
- ADDR_WIDTH, 32, byte address width on all three ports.
- LINE_WIDTH, 256, cacheline width in bits (32-byte line; low 5 address bits ignored).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- i_addr  input  ADDR_WIDTH  icache line address
- i_read  input  1  icache read request, held until i_resp
- i_rdata  output  LINE_WIDTH  line returned to icache
- i_resp  output  1  one-cycle icache completion pulse
- d_addr  input  ADDR_WIDTH  dcache line address
- d_read  input  1  dcache read request, held until d_resp
- d_write  input  1  dcache write-back request, held until d_resp
- d_wdata  input  LINE_WIDTH  dcache write-back line
- d_rdata  output  LINE_WIDTH  line returned to dcache
- d_resp  output  1  one-cycle dcache completion pulse
- m_addr  output  ADDR_WIDTH  memory line address, low 5 bits forced to 0
- m_read  output  1  memory read, held until m_resp
- m_write  output  1  memory write, held until m_resp
- m_wdata  output  LINE_WIDTH  memory write line
- m_rdata  input  LINE_WIDTH  memory read line, valid with m_resp
- m_resp  input  1  memory completion pulse

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs are 0; state is IDLE; owner is NONE.
  - Reset mid-transaction abandons it with no response issued. The memory adapter shares this reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any request is high, pick a winner.
  - Latch winner address (low 5 bits zeroed), wdata and read/write type into the m_* registers; set owner.
  - Go to BUSY. m_read/m_write assert the next cycle (grant latency 1 cycle).
- BUSY:
  - m_* outputs are held stable.
  - On m_resp: latch m_rdata into the owner's rdata register (write-backs latch nothing), drop m_read/m_write, go to RESP.
- RESP:
  - Pulse the owner's resp for exactly 1 cycle, then go to IDLE.
  - Requester observes resp and deasserts the cycle after. IDLE therefore never re-grants a stale request.
- Latency: request seen at cycle t gives m_read at t+1. m_resp at cycle u gives requester resp at u+1. Minimum back-to-back spacing is 3 cycles per transaction.
- i_rdata and d_rdata hold their last value until overwritten.
- Only the owner's rdata register changes.
- Arbitration (default): fixed priority, dcache over icache.
- Simultaneous i_read and d_read/d_write in IDLE: dcache wins; icache waits, its request still held.
- Requests arriving in BUSY/RESP are ignored until IDLE.
- d_read and d_write both high is illegal (assertion). If it occurs, the write is served.
- A requester changing its address while pending is illegal (assertion, no effect once latched).
- m_resp outside BUSY is ignored (assertion).

Optional Feature:
- Macro: CACHELINE_ARB_RR_EN.
- Defined:
  - Round-robin arbitration using a 1-bit last-owner register, reset to icache.
  - On a simultaneous request, the source that did not win last is granted.
  - The register updates on each grant.
- Undefined: fixed dcache-over-icache priority as above; no extra state.

Decomposition:
- Shared package (mem_types):
  - arb_state_t enum {IDLE, BUSY, RESP}
  - arb_src_t enum {SRC_NONE, SRC_I, SRC_D}
  - LINE_WIDTH/LINE_OFFSET constants, reused by both caches.
- One natural sub-module: cacheline_arb_pick.
  - Combinational winner select from i_read, d_read|d_write and last-owner.
  - Contains the round-robin logic under the macro.

Test Plan:
- Isolated icache read: i_addr=0x0000_1234 at t → m_read=1, m_addr=0x0000_1220 at t+1. Memory returns m_rdata=0xA5…A5 at t+4 → i_resp=1 at t+5 with i_rdata=0xA5…A5; d_resp stays 0.
- Dcache write-back: d_write, d_addr=0x8000_0040, d_wdata=0x1111… → m_write=1 with matching address and data, m_read=0. m_resp → d_resp one cycle later; d_rdata unchanged.
- Simultaneous i_read(0x100) and d_read(0x200), macro undefined → dcache served first. Icache is granted in IDLE after d_resp; memory sees 0x200 then 0x100.
- Same simultaneous pattern repeated twice with CACHELINE_ARB_RR_EN → grant order icache? No: first grant D (last-owner reset = I), then I, then D, then I.
- Reset pulse (rst low) while BUSY → all outputs 0 immediately, asynchronously. After release with no requests, m_read stays 0; no i_resp or d_resp ever issued for the aborted transaction.
- m_resp delayed 50 cycles → m_addr, m_wdata and m_read stable throughout; exactly one resp pulse results.
